lsu_warp_serializer: RTL and testbench

- Load/store unit sitting directly upstream of the single-port data memory.
- Accepts one warp-wide memory request: up to N_LANES lanes, with a lane mask.
- Issues one lane access per cycle on the data-memory port and collects load data per lane.
- Returns a packed warp response to the execute stage through a valid/ready handshake.

---
 rtl/lsu_warp_serializer.sv | 132 +++++++++++++
 tb/tb_lsu_warp_serializer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/lsu_warp_serializer.sv
// lsu_warp_serializer: takes one warp-wide load/store request and serializes it
// onto the single-port data memory, one lane access per cycle (lowest active
// lane first), then returns the packed per-lane load data over valid/ready.
// Optional build macro: LSU_LOAD_COALESCE_EN -- loads service every pending
// lane that shares the current lane's address in the same ACCESS cycle.
module lsu_warp_serializer #(
    parameter int N_LANES = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [N_LANES-1:0]          req_mask,
    input  logic [N_LANES*ADDR_W-1:0]   req_addr,
    input  logic [N_LANES*DATA_W-1:0]   req_wdata,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [N_LANES*DATA_W-1:0]   resp_rdata,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int LANE_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t                      r_state;
    logic                        r_we;
    logic [N_LANES-1:0]          r_pending;
    logic [N_LANES*ADDR_W-1:0]   r_addr;
    logic [N_LANES*DATA_W-1:0]   r_wdata;
    logic [N_LANES*DATA_W-1:0]   r_rdata;

    logic [LANE_W-1:0]           w_lane;
    logic [ADDR_W-1:0]           w_lane_addr;
    logic [DATA_W-1:0]           w_lane_wdata;
    logic [N_LANES-1:0]          w_service;
    logic [N_LANES-1:0]          w_pending_next;
    logic                        w_in_access;

    // Priority pick of the lowest pending lane (scan high to low, last hit wins).
    always_comb begin
        w_lane = '0;
        for (int i = N_LANES - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_lane = LANE_W'(i);
            end
        end
    end

    assign w_lane_addr  = r_addr[w_lane*ADDR_W +: ADDR_W];
    assign w_lane_wdata = r_wdata[w_lane*DATA_W +: DATA_W];

    // Lanes completed this cycle: the selected lane, plus (coalescing loads
    // only) every other pending lane reading the same address.
    generate
        for (genvar gi = 0; gi < N_LANES; gi++) begin : g_service
`ifdef LSU_LOAD_COALESCE_EN
            assign w_service[gi] = r_pending[gi] &&
                ((LANE_W'(gi) == w_lane) ||
                 (!r_we && (r_addr[gi*ADDR_W +: ADDR_W] == w_lane_addr)));
`else
            assign w_service[gi] = r_pending[gi] && (LANE_W'(gi) == w_lane);
`endif
        end
    endgenerate

    assign w_pending_next = r_pending & ~w_service;
    assign w_in_access    = (r_state == ST_ACCESS);

    // Memory port is only live in ACCESS; it idles at zero otherwise.
    assign mem_we    = w_in_access && r_we;
    assign mem_addr  = w_in_access ? w_lane_addr  : '0;
    assign mem_wdata = w_in_access ? w_lane_wdata : '0;

    assign req_ready  = (r_state == ST_IDLE);
    assign resp_valid = (r_state == ST_RESP);
    assign resp_rdata = r_rdata;

    // Request FSM: latch the warp, walk the pending mask, hold the response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_we      <= 1'b0;
            r_pending <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_we      <= req_we;
                        r_pending <= req_mask;
                        r_addr    <= req_addr;
                        r_wdata   <= req_wdata;
                        r_rdata   <= '0;
                        r_state   <= (req_mask != '0) ? ST_ACCESS : ST_RESP;
                    end
                end
                ST_ACCESS: begin
                    // Stores leave the result lanes at zero.
                    for (int i = 0; i < N_LANES; i++) begin
                        if (w_service[i] && !r_we) begin
                            r_rdata[i*DATA_W +: DATA_W] <= mem_rdata;
                        end
                    end
                    r_pending <= w_pending_next;
                    if (w_pending_next == '0) begin
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_warp_serializer.sv
// Scoreboard bench for lsu_warp_serializer: stimulus pushes expected responses,
// a negedge monitor pops and compares them and logs every memory access.
// Optional build macro: LSU_LOAD_COALESCE_EN (changes expected access counts).
module tb_lsu_warp_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_mask;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    lsu_warp_serializer #(.N_LANES(4), .ADDR_W(8), .DATA_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_mask   (req_mask),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Data memory model: combinational read, write on posedge, plus a backdoor.
    logic [7:0] mem [256];
    logic       bd_we = 1'b0;
    logic [7:0] bd_addr = 8'h00;
    logic [7:0] bd_data = 8'h00;
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    int n_cmp = 0;
    int n_mis = 0;
    logic [31:0] exp_q[$];
    logic [8:0]  acc_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare responses on handshake, record ACCESS-cycle memory traffic.
    always @(negedge clk) begin
        if (!reset && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL resp_unexpected: got %0h expected no response", resp_rdata);
            end else begin
                chk("resp_rdata", resp_rdata, exp_q.pop_front());
            end
        end
        if (!reset && !req_ready && !resp_valid)
            acc_q.push_back({mem_we, mem_addr});
    end

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    // One request: called and returns just after a posedge.
    task automatic do_req(input string name, input logic we, input logic [3:0] mask,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input int k, input int stall,
                          input logic [35:0] exp_acc);
        int cyc;
        acc_q.delete();
        exp_q.push_back(exp_rd);
        resp_ready = (stall == 0);
        req_valid = 1'b1; req_we = we; req_mask = mask; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        chk({name, "_req_ready"}, 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 1;
        @(negedge clk);
        while (!resp_valid && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
        chk({name, "_latency"}, 64'(cyc), 64'(k + 1));
        if (stall > 0) begin
            for (int s = 0; s < stall; s++) begin
                chk({name, "_stall_hold"}, {30'd0, resp_valid, req_ready, resp_rdata},
                    {30'd0, 1'b1, 1'b0, exp_rd});
                @(negedge clk);
            end
            @(posedge clk); #1;
            resp_ready = 1'b1;
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk({name, "_back_idle"}, {62'd0, resp_valid, req_ready}, 64'd1);
        chk({name, "_acc_count"}, 64'(acc_q.size()), 64'(k));
        for (int i = 0; i < k && i < 4; i++) begin
            if (i < acc_q.size())
                chk({name, "_acc_entry"}, 64'(acc_q[i]), 64'(exp_acc[i*9 +: 9]));
        end
        chk({name, "_resp_popped"}, 64'(exp_q.size()), 64'd0);
        $display("txn %s we=%0b mask=%b addr=%h wdata=%h rdata=%h cycles=%0d",
                 name, we, mask, addr, wdata, resp_rdata, cyc);
        @(posedge clk); #1;
    endtask

    int k_co;
    logic [35:0] acc_co;

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_mask = '0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
        #2;
        chk("reset_outputs", {resp_valid, req_ready, mem_we, mem_addr, resp_rdata},
            {1'b0, 1'b1, 1'b0, 8'h00, 32'h0});
        for (int i = 0; i < 32; i++) poke(8'(i), 8'h00);
        @(posedge clk); #1;
        reset = 1'b0;
        poke(8'd0, 8'h10); poke(8'd1, 8'h11); poke(8'd2, 8'h12); poke(8'd3, 8'h13);

        do_req("load4", 1'b0, 4'b1111, 32'h03020100, 32'h0, 32'h13121110, 4, 0,
               {9'h003, 9'h002, 9'h001, 9'h000});

        do_req("store2", 1'b1, 4'b0101, 32'h0A090605, 32'h00BBCCAA, 32'h0, 2, 0,
               {9'h000, 9'h000, 9'h109, 9'h105});
        chk("store2_mem5", 64'(mem[5]), 64'hAA);
        chk("store2_mem9", 64'(mem[9]), 64'hBB);
        chk("store2_mem6", 64'(mem[6]), 64'h00);

        do_req("store_dup", 1'b1, 4'b0011, 32'h00000707, 32'h00000201, 32'h0, 2, 0,
               {9'h000, 9'h000, 9'h107, 9'h107});
        chk("store_dup_mem7", 64'(mem[7]), 64'h02);

        do_req("empty_mask", 1'b1, 4'b0000, 32'h01020304, 32'hFFFFFFFF, 32'h0, 0, 0, 36'h0);

        do_req("load_stall", 1'b0, 4'b1010, 32'h001F021E, 32'h0, 32'h10001200, 2, 5,
               {9'h000, 9'h000, 9'h000, 9'h002});

        poke(8'd3, 8'h33); poke(8'd8, 8'h88);
`ifdef LSU_LOAD_COALESCE_EN
        k_co = 2; acc_co = {9'h000, 9'h000, 9'h008, 9'h003};
`else
        k_co = 4; acc_co = {9'h003, 9'h008, 9'h003, 9'h003};
`endif
        do_req("load_same_addr", 1'b0, 4'b1111, 32'h03080303, 32'h0, 32'h33883333, k_co, 0, acc_co);

        // Reset during the second ACCESS cycle of a 4-lane store.
        acc_q.delete();
        resp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_mask = 4'b1111;
        req_addr = 32'h17161514; req_wdata = 32'hD3D2D1D0;
        @(negedge clk);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("midreset_outputs", {resp_valid, req_ready, mem_we, mem_addr},
            {1'b0, 1'b1, 1'b0, 8'h00});
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("midreset_mem20", 64'(mem[20]), 64'hD0);
        chk("midreset_mem21_23", {mem[21], mem[22], mem[23]}, 24'h0);
        chk("midreset_acc_count", 64'(acc_q.size()), 64'd1);
        $display("txn midreset_store we=1 mask=1111 addr=17161514 wdata=D3D2D1D0 aborted");

        do_req("load_after_reset", 1'b0, 4'b0001, 32'h00000014, 32'h0, 32'h000000D0, 1, 0,
               {9'h000, 9'h000, 9'h000, 9'h014});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
